// File: rtl/stc_b_dn_pipe_pkg.sv
// Shared definitions for the B-operand distribution network: default
// geometry, the swap-control state type and small index helpers.
package stc_b_dn_pipe_pkg;

  localparam int K_DEF       = 16;
  localparam int N_DEF       = 16;
  localparam int DW_DATA_DEF = 16;
  localparam int N_PE_DEF    = 4;

  typedef enum logic {
    SW_IDLE    = 1'b0,
    SW_PENDING = 1'b1
  } swap_state_e;

  // Ceiling log2 for sizing row indices; callers guarantee v >= 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // True when a zero-extended row index addresses a real row of B.
  function automatic logic row_in_range(input logic [31:0] row, input int k);
    return row < 32'(k);
  endfunction

endpackage

// File: rtl/stc_b_dn_pipe_row_bank.sv
// Double-buffered B row store: two banks of K rows, one write port and
// N_PE independent combinational read ports.
module stc_b_row_bank
  import stc_b_dn_pipe_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int ROW_W = N_DEF * DW_DATA_DEF,
  parameter int N_PE  = N_PE_DEF,
  localparam int DW_COL = clog2(K)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_bank,
  input  logic [DW_COL-1:0]       wr_row,
  input  logic [ROW_W-1:0]        wr_data,
  input  logic [N_PE-1:0]         rd_bank,
  input  logic [N_PE*DW_COL-1:0]  rd_row,
  output logic [N_PE*ROW_W-1:0]   rd_data
);

  logic [ROW_W-1:0] mem_q [2][K];

  // Row store: cleared by reset, single row written per cycle, out-of-range rows dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < K; r++) begin
          mem_q[b][r] <= '0;
        end
      end
    end else if (wr_en && row_in_range(32'(wr_row), K)) begin
      mem_q[wr_bank][wr_row] <= wr_data;
    end
  end

  // Per-lane read ports; a row index beyond K reads as zero.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N_PE; p++) begin
      if (row_in_range(32'(rd_row[p*DW_COL +: DW_COL]), K)) begin
        rd_data[p*ROW_W +: ROW_W] = mem_q[rd_bank[p]][rd_row[p*DW_COL +: DW_COL]];
      end
    end
  end

endmodule

// File: rtl/stc_b_dn_pipe.sv
// Pipelined B-operand distribution network: S1 captures the request and
// the read bank it belongs to, S2 gathers one B row per PE lane. Bank
// swaps wait until S1 is empty so no captured request loses its bank.
module stc_b_dn_pipe
  import stc_b_dn_pipe_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int N       = N_DEF,
  parameter int DW_DATA = DW_DATA_DEF,
  parameter int N_PE    = N_PE_DEF,
  localparam int DW_COL = clog2(K)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      b_wr_en,
  input  logic [DW_COL-1:0]         b_wr_row,
  input  logic [N*DW_DATA-1:0]      b_wr_data,
  input  logic                      b_swap,
  output logic                      swap_busy,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_PE*DW_COL-1:0]    in_cols,
  input  logic [N_PE-1:0]           in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PE*N*DW_DATA-1:0] out_b,
  output logic [N_PE-1:0]           out_mask
);

  localparam int ROW_W = N * DW_DATA;

  logic                     ready_en_q;
  logic                     rd_bank_q;
  swap_state_e              swap_q;
  logic                     s1_valid_q;
  logic [N_PE*DW_COL-1:0]   s1_cols_q;
  logic [N_PE-1:0]          s1_mask_q;
  logic                     s1_bank_q;
  logic                     out_valid_q;
  logic [N_PE*ROW_W-1:0]    out_b_q;
  logic [N_PE-1:0]          out_mask_q;

  logic                     s2_adv;
  logic                     accept;
  logic                     swap_pend;
  logic                     flip;
  logic                     wr_bank;
  logic [N_PE-1:0]          rd_bank_v;
  logic [N_PE*ROW_W-1:0]    rd_data;
  logic [N_PE*ROW_W-1:0]    out_b_d;
  logic [N_PE-1:0]          out_mask_d;

  assign swap_busy = (swap_q == SW_PENDING);
  assign out_valid = out_valid_q;
  assign out_b     = out_b_q;
  assign out_mask  = out_mask_q;
  assign wr_bank   = ~rd_bank_q;
  assign rd_bank_v = {N_PE{s1_bank_q}};

  // Handshake and swap decision: flip only when S1 will be empty after this edge.
  always_comb begin
    s2_adv    = ~out_valid_q | out_ready;
    in_ready  = ready_en_q & (swap_q == SW_IDLE) & (~s1_valid_q | s2_adv);
    accept    = in_valid & in_ready;
    swap_pend = (swap_q == SW_PENDING) | b_swap;
    flip      = swap_pend & ~accept & (~s1_valid_q | s2_adv);
  end

  // Lane gather from the bank captured in S1; inactive or out-of-range lanes are zero.
  always_comb begin
    out_b_d    = '0;
    out_mask_d = '0;
    for (int p = 0; p < N_PE; p++) begin
      out_mask_d[p] = s1_mask_q[p] & row_in_range(32'(s1_cols_q[p*DW_COL +: DW_COL]), K);
      if (out_mask_d[p]) begin
        out_b_d[p*ROW_W +: ROW_W] = rd_data[p*ROW_W +: ROW_W];
      end
    end
  end

  // Read-bank selection, pending-swap tracking and post-reset input enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      swap_q     <= SW_IDLE;
    end else begin
      ready_en_q <= 1'b1;
      if (flip) rd_bank_q <= ~rd_bank_q;
      swap_q <= (swap_pend && !flip) ? SW_PENDING : SW_IDLE;
    end
  end

  // S1: capture an accepted request together with the bank it must read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_cols_q  <= '0;
      s1_mask_q  <= '0;
      s1_bank_q  <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_cols_q  <= in_cols;
      s1_mask_q  <= in_mask;
      s1_bank_q  <= rd_bank_q;
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: register gathered rows; holds steady while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_b_q     <= '0;
      out_mask_q  <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_b_q    <= out_b_d;
        out_mask_q <= out_mask_d;
      end
    end
  end

  stc_b_row_bank #(
    .K     (K),
    .ROW_W (ROW_W),
    .N_PE  (N_PE)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (b_wr_en),
    .wr_bank (wr_bank),
    .wr_row  (b_wr_row),
    .wr_data (b_wr_data),
    .rd_bank (rd_bank_v),
    .rd_row  (s1_cols_q),
    .rd_data (rd_data)
  );

endmodule
